// File: rtl/exec_control.sv
// ---------------------------------------------------------------------------
// exec_control
//
// Run/stop/step controller for a hand-operated processor front panel.
// A raw, bouncing, active-low EXEC push-button is synchronized and
// debounced into a single-cycle press pulse. A small FSM uses that pulse,
// together with the processor's halt pulse and the phase generator's
// end-of-cycle pulse, to decide whether the phase-clock generator runs.
// The FSM also drives a seven-segment status pattern.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive clock cycles a new button level must hold
//                    before it is accepted (2..65535)
//
// Ports
//   clock       in   system clock, everything updates on its rising edge
//   reset       in   synchronous active-high reset
//   execbutton  in   raw push-button, active-low, asynchronous, may bounce
//   stepmode    in   1 = a press from IDLE runs one instruction cycle only
//   halt        in   one-cycle pulse from the processor's halt instruction
//   phaseend    in   one-cycle pulse at the end of an instruction cycle
//   running     out  enable for the phase-clock generator
//   ispressed   out  one-cycle pulse per accepted button press
//   statusled   out  seven-segment status pattern
//   state       out  FSM state code (IDLE=0 RUN=1 STOPPING=2 STEP=3 HALTED=4)
// ---------------------------------------------------------------------------
module exec_control #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       execbutton,
  input  logic       stepmode,
  input  logic       halt,
  input  logic       phaseend,
  output logic       running,
  output logic       ispressed,
  output logic [7:0] statusled,
  output logic [2:0] state
);

  // State codes are part of the external interface, so they are fixed
  // constants rather than an enum.
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RUN      = 3'd1;
  localparam logic [2:0] STOPPING = 3'd2;
  localparam logic [2:0] STEP     = 3'd3;
  localparam logic [2:0] HALTED   = 3'd4;

  localparam logic [7:0] LED_ACTIVE = 8'b10011110;
  localparam logic [7:0] LED_IDLE   = 8'b10110110;
  localparam logic [7:0] LED_HALTED = 8'b10001110;

  // Counter value at which a differing level has held long enough.
  localparam logic [15:0] DEBOUNCE_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync_meta;
  logic        sync_level;
  logic        stable;
  logic        stable_prev;
  logic [15:0] counter;
  logic [2:0]  next_state;

  // Two-flop synchronizer for the asynchronous button. Reset to the
  // released level (1) so that a button held through reset is seen as a
  // brand-new press that must be debounced from scratch.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta  <= 1'b1;
      sync_level <= 1'b1;
    end else begin
      sync_meta  <= execbutton;
      sync_level <= sync_meta;
    end
  end

  // Debouncer: the counter measures how long the synchronized level has
  // disagreed with the accepted level. Any agreeing sample restarts the
  // count, so only an uninterrupted run of DEBOUNCE_CYCLES differing
  // samples changes the accepted level.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable  <= 1'b1;
      counter <= 16'd0;
    end else if (sync_level == stable) begin
      counter <= 16'd0;
    end else if (counter == DEBOUNCE_LAST) begin
      stable  <= sync_level;
      counter <= 16'd0;
    end else begin
      counter <= counter + 16'd1;
    end
  end

  // Press pulse: registered falling-edge detect on the accepted level.
  // It fires the cycle after the accepted level drops; releases are silent.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_prev <= 1'b1;
      ispressed   <= 1'b0;
    end else begin
      stable_prev <= stable;
      ispressed   <= stable_prev & ~stable;
    end
  end

  // Next-state logic. halt is checked first wherever it is honoured, so it
  // beats a coincident press or phaseend. STOPPING and STEP only leave on
  // phaseend, which keeps the phase clock running to the end of the
  // current instruction cycle. Unused codes fall back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ispressed) begin
          next_state = stepmode ? STEP : RUN;
        end
      end
      RUN: begin
        if (halt) begin
          next_state = HALTED;
        end else if (ispressed) begin
          next_state = STOPPING;
        end
      end
      STOPPING, STEP: begin
        if (halt) begin
          next_state = HALTED;
        end else if (phaseend) begin
          next_state = IDLE;
        end
      end
      HALTED: begin
        if (ispressed) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are pure decodes of the state register so they move on the
  // same edge as the state itself.
  always_comb begin
    running   = 1'b0;
    statusled = LED_IDLE;
    case (state)
      RUN, STOPPING, STEP: begin
        running   = 1'b1;
        statusled = LED_ACTIVE;
      end
      HALTED: begin
        statusled = LED_HALTED;
      end
      default: begin
        running   = 1'b0;
        statusled = LED_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exec_control.sv
// ---------------------------------------------------------------------------
// tb_exec_control
//
// Self-checking bench for exec_control with DEBOUNCE_CYCLES = 4. A
// behavioural model (sample history window for the debouncer, a transition
// table for the controller) predicts every output after every clock edge.
// Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_exec_control;

  localparam int D = 4;

  logic       clock;
  logic       reset;
  logic       execbutton;
  logic       stepmode;
  logic       halt;
  logic       phaseend;
  logic       running;
  logic       ispressed;
  logic [7:0] statusled;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state
  int   m_state;
  bit   m_press;
  bit   m_fell;
  bit   m_stable;
  bit   m_s1;
  bit   m_s2;
  bit   lvl_q[$];

  exec_control #(.DEBOUNCE_CYCLES(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .execbutton (execbutton),
    .stepmode   (stepmode),
    .halt       (halt),
    .phaseend   (phaseend),
    .running    (running),
    .ispressed  (ispressed),
    .statusled  (statusled),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Controller behaviour as a transition table over state numbers.
  function automatic int fsm_next(int st, bit press, bit h, bit pe, bit sm);
    case (st)
      0: return press ? (sm ? 3 : 1) : 0;
      1: return h ? 4 : (press ? 2 : 1);
      2: return h ? 4 : (pe ? 0 : 2);
      3: return h ? 4 : (pe ? 0 : 3);
      4: return press ? 0 : 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] led_of(int st);
    if (st == 0) return 8'b10110110;
    if (st == 4) return 8'b10001110;
    return 8'b10011110;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge: advance the model with the pre-edge inputs, then
  // compare all outputs shortly after the edge.
  task automatic step();
    bit all_differ;
    @(posedge clock);
    cyc++;
    if (reset) begin
      m_state  = 0;
      m_press  = 0;
      m_fell   = 0;
      m_stable = 1;
      m_s1     = 1;
      m_s2     = 1;
      lvl_q.delete();
    end else begin
      m_state = fsm_next(m_state, m_press, halt, phaseend, stepmode);
      m_press = m_fell;
      m_fell  = 0;
      lvl_q.push_back(m_s2);
      if (lvl_q.size() > D) void'(lvl_q.pop_front());
      all_differ = (lvl_q.size() == D);
      foreach (lvl_q[i]) if (lvl_q[i] == m_stable) all_differ = 0;
      if (all_differ) begin
        m_stable = ~m_stable;
        m_fell   = (m_stable == 0);
        lvl_q.delete();
      end
      m_s2 = m_s1;
      m_s1 = execbutton;
    end
    #1;
    check("model_state", 8'(state), 8'(m_state));
    check("model_running", 8'(running), 8'((m_state >= 1 && m_state <= 3) ? 1 : 0));
    check("model_ispressed", 8'(ispressed), 8'(m_press));
    check("model_statusled", statusled, led_of(m_state));
  endtask

  task automatic press_button();
    execbutton = 1'b0;
    repeat (D + 3) step();
  endtask

  task automatic release_button();
    execbutton = 1'b1;
    repeat (D + 3) step();
  endtask

  initial begin
    int hold;
    reset      = 1'b1;
    execbutton = 1'b1;
    stepmode   = 1'b0;
    halt       = 1'b0;
    phaseend   = 1'b0;

    // Reset and first press with exact latency
    step();
    step();
    reset = 1'b0;
    check("reset_state", 8'(state), 8'd0);
    check("reset_led", statusled, 8'b10110110);
    check("reset_running", 8'(running), 8'd0);
    check("reset_ispressed", 8'(ispressed), 8'd0);
    while (cyc < 9) step();
    execbutton = 1'b0;
    while (cyc < 15) step();
    check("latency_early", 8'(ispressed), 8'd0);
    step();
    check("latency_pulse", 8'(ispressed), 8'd1);
    step();
    check("press_run_state", 8'(state), 8'd1);
    check("press_run_running", 8'(running), 8'd1);
    check("press_run_led", statusled, 8'b10011110);
    check("pulse_one_cycle", 8'(ispressed), 8'd0);
    release_button();
    check("release_no_stop", 8'(state), 8'd1);

    // Press in RUN then phaseend five cycles later
    press_button();
    execbutton = 1'b1;
    step();
    check("stopping_state", 8'(state), 8'd2);
    repeat (4) begin
      step();
      check("stopping_running", 8'(running), 8'd1);
    end
    phaseend = 1'b1;
    step();
    phaseend = 1'b0;
    check("stop_idle_state", 8'(state), 8'd0);
    check("stop_idle_running", 8'(running), 8'd0);
    release_button();

    // Bounce never reaches the debounce length
    execbutton = 1'b0; repeat (3) step();
    execbutton = 1'b1; step();
    execbutton = 1'b0; repeat (3) step();
    execbutton = 1'b1;
    repeat (8) begin
      step();
      check("bounce_nopress", 8'(ispressed), 8'd0);
    end
    check("bounce_idle", 8'(state), 8'd0);

    // Single step; second press ignored
    stepmode = 1'b1;
    press_button();
    execbutton = 1'b1;
    step();
    check("step_state", 8'(state), 8'd3);
    check("step_running", 8'(running), 8'd1);
    stepmode = 1'b0;
    release_button();
    press_button();
    step();
    check("step_press_ignored", 8'(state), 8'd3);
    release_button();
    phaseend = 1'b1;
    step();
    phaseend = 1'b0;
    check("step_done_idle", 8'(state), 8'd0);

    // halt wins over a coincident press in RUN
    press_button();
    execbutton = 1'b1;
    step();
    release_button();
    press_button();
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_state", 8'(state), 8'd4);
    check("halt_led", statusled, 8'b10001110);
    check("halt_running", 8'(running), 8'd0);
    release_button();
    press_button();
    step();
    check("halt_press_idle", 8'(state), 8'd0);
    release_button();

    // Reset in STOPPING with button still held
    press_button();
    execbutton = 1'b1;
    step();
    release_button();
    press_button();
    step();
    check("pre_reset_stopping", 8'(state), 8'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midstop_reset_state", 8'(state), 8'd0);
    check("midstop_reset_running", 8'(running), 8'd0);
    repeat (D + 2) begin
      step();
      check("post_reset_nopress", 8'(ispressed), 8'd0);
    end
    step();
    check("post_reset_fresh_press", 8'(ispressed), 8'd1);
    release_button();

    // Randomized traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        execbutton = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      halt     = ($urandom_range(0, 19) == 0);
      phaseend = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) stepmode = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
